// File: rtl/pref_issue_queue.sv
// pref_issue_queue: FIFO sequencing up to 3 block-aligned prefetch candidates per cycle onto a valid/ready request port, dropping overflow into a saturating counter; define PREF_IQ_DEDUP_EN to discard candidates already queued or repeated within a cycle
module pref_issue_queue #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 64,
  parameter int LOG2_BLOCK_SIZE = 6,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          cand_addr1_i,
  input  logic [ADDR_W-1:0]          cand_addr2_i,
  input  logic [ADDR_W-1:0]          cand_addr3_i,
  input  logic                       cand_valid1_i,
  input  logic                       cand_valid2_i,
  input  logic                       cand_valid3_i,
  output logic                       req_valid_o,
  output logic [ADDR_W-1:0]          req_addr_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [ADDR_W-1:0] MASK = ~((ADDR_W'(1) << LOG2_BLOCK_SIZE) - ADDR_W'(1));
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail, occ, free;
  logic [ADDR_W-1:0] a [3];
  logic [2:0] v, acc;
  logic [1:0] pos [3];
  logic [IW-1:0] widx [3];
  logic [1:0] nv, np;
  logic [CNT_W:0] dsum;
  logic pop;
`ifdef PREF_IQ_DEDUP_EN
  logic [IW-1:0] off [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_off
    assign off[i] = IW'(i) - head[IW-1:0];
  end
`endif
  assign occ = tail - head;
  assign free = PW'(DEPTH) - occ;
  assign occupancy_o = occ;
  assign req_valid_o = occ != '0;
  assign req_addr_o = mem[head[IW-1:0]];
  assign pop = req_valid_o && req_ready_i;
  always_comb begin
    a[0] = cand_addr1_i & MASK;
    a[1] = cand_addr2_i & MASK;
    a[2] = cand_addr3_i & MASK;
    v = {cand_valid3_i, cand_valid2_i, cand_valid1_i};
`ifdef PREF_IQ_DEDUP_EN
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++)
        if (PW'(off[i]) < occ && mem[i] == a[k]) v[k] = 1'b0;
    if (cand_valid1_i && a[1] == a[0]) v[1] = 1'b0;
    if ((cand_valid1_i && a[2] == a[0]) || (cand_valid2_i && a[2] == a[1])) v[2] = 1'b0;
`endif
    pos[0] = 2'd0;
    pos[1] = 2'(v[0]);
    pos[2] = 2'(v[0]) + 2'(v[1]);
    nv = pos[2] + 2'(v[2]);
    for (int k = 0; k < 3; k++) begin
      acc[k] = v[k] && (PW'(pos[k]) < free);
      widx[k] = tail[IW-1:0] + IW'(pos[k]);
    end
    np = 2'(acc[0]) + 2'(acc[1]) + 2'(acc[2]);
    dsum = {1'b0, drop_cnt_o} + (CNT_W+1)'(nv - np);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      drop_cnt_o <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (acc[k]) mem[widx[k]] <= a[k];
      tail <= tail + PW'(np);
      head <= head + PW'(pop);
      drop_cnt_o <= dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_pref_issue_queue.sv
// tb_pref_issue_queue: directed vector table plus hand sequences for pref_issue_queue
module tb_pref_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] c1 = '0, c2 = '0, c3 = '0;
  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic rdy = 1'b0;
  logic req_valid;
  logic [63:0] req_addr;
  logic [3:0] occ;
  logic [15:0] drop;
  int n_cmp = 0;
  int n_fail = 0;

  pref_issue_queue dut (
    .clk(clk), .rst(rst),
    .cand_addr1_i(c1), .cand_addr2_i(c2), .cand_addr3_i(c3),
    .cand_valid1_i(v1), .cand_valid2_i(v2), .cand_valid3_i(v3),
    .req_valid_o(req_valid), .req_addr_o(req_addr), .req_ready_i(rdy),
    .occupancy_o(occ), .drop_cnt_o(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] c1, c2, c3;
    logic [2:0]  v;
    logic        rdy;
    logic        ev;
    logic [63:0] ea;
    int          eocc;
    int          edrop;
  } vec_t;
  vec_t tbl [23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3,
                       input logic [2:0] v, input logic r);
    c1 = a1; c2 = a2; c3 = a3;
    {v3, v2, v1} = v;
    rdy = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic ev, input logic [63:0] ea,
                              input int eocc, input int edrop);
    chk({name, "_valid"}, 64'(req_valid), 64'(ev));
    if (ev) chk({name, "_addr"}, req_addr, ea);
    chk({name, "_occ"}, 64'(occ), 64'(eocc));
    chk({name, "_drop"}, 64'(drop), 64'(edrop));
  endtask

  logic [63:0] exp_q [$];

  initial begin
    tbl[0]  = '{64'h1040, 64'h1080, 64'h10C7, 3'b111, 1'b1, 1'b1, 64'h1040, 3, 0};
    tbl[1]  = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h1080, 2, 0};
    tbl[2]  = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h10C0, 1, 0};
    tbl[3]  = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b0, 64'h0,    0, 0};
    tbl[4]  = '{64'h4000, 64'h4040, 64'h4080, 3'b111, 1'b0, 1'b1, 64'h4000, 3, 0};
    tbl[5]  = '{64'h40C0, 64'h4100, 64'h4140, 3'b111, 1'b0, 1'b1, 64'h4000, 6, 0};
    tbl[6]  = '{64'h4180, 64'h41C0, 64'h4200, 3'b111, 1'b0, 1'b1, 64'h4000, 8, 1};
    tbl[7]  = '{64'h5000, 64'h5040, 64'h5080, 3'b111, 1'b1, 1'b1, 64'h4040, 7, 4};
    tbl[8]  = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h4080, 6, 4};
    tbl[9]  = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h40C0, 5, 4};
    tbl[10] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h4100, 4, 4};
    tbl[11] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h4140, 3, 4};
    tbl[12] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h4180, 2, 4};
    tbl[13] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h41C0, 1, 4};
    tbl[14] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b0, 64'h0,    0, 4};
    tbl[15] = '{64'h2000, 64'h0,    64'h0,    3'b001, 1'b0, 1'b1, 64'h2000, 1, 4};
    tbl[16] = '{64'h0,    64'h0,    64'h2040, 3'b100, 1'b0, 1'b1, 64'h2000, 2, 4};
    tbl[17] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b0, 1'b1, 64'h2000, 2, 4};
    tbl[18] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b0, 1'b1, 64'h2000, 2, 4};
    tbl[19] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b0, 1'b1, 64'h2000, 2, 4};
    tbl[20] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b0, 1'b1, 64'h2000, 2, 4};
    tbl[21] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b1, 64'h2040, 1, 4};
    tbl[22] = '{64'h0,    64'h0,    64'h0,    3'b000, 1'b1, 1'b0, 64'h0,    0, 4};

    drive(64'h7000, 64'h7040, 64'h7080, 3'b111, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_state($sformatf("reset%0d", i), 1'b0, 64'h0, 0, 0);
      chk($sformatf("reset%0d_addr", i), req_addr, 64'h0);
    end
    drive(64'h0, 64'h0, 64'h0, 3'b000, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].v, tbl[i].rdy);
      tick();
      expect_state($sformatf("row%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eocc, tbl[i].edrop);
    end

    for (int j = 0; j < 20; j++) begin
      drive(64'h0, 64'h6000 + 64'(j) * 64'h40 + 64'h5, 64'h0, 3'b010, 1'b1);
      tick();
      expect_state($sformatf("wrap%0d", j), 1'b1, 64'h6000 + 64'(j) * 64'h40, 1, 4);
    end
    drive(64'h0, 64'h0, 64'h0, 3'b000, 1'b1);
    tick();
    expect_state("wrap_drain", 1'b0, 64'h0, 0, 4);

    drive(64'h3000, 64'h0, 64'h0, 3'b001, 1'b0);
    tick();
    expect_state("dup_seed", 1'b1, 64'h3000, 1, 4);
    drive(64'h3000, 64'h3040, 64'h3040, 3'b111, 1'b0);
    tick();
`ifdef PREF_IQ_DEDUP_EN
    expect_state("dup_push", 1'b1, 64'h3000, 2, 4);
    exp_q = '{64'h3000, 64'h3040};
`else
    expect_state("dup_push", 1'b1, 64'h3000, 4, 4);
    exp_q = '{64'h3000, 64'h3000, 64'h3040, 64'h3040};
`endif
    drive(64'h0, 64'h0, 64'h0, 3'b000, 1'b1);
    foreach (exp_q[k]) begin
      chk($sformatf("dup_issue%0d_valid", k), 64'(req_valid), 64'h1);
      chk($sformatf("dup_issue%0d_addr", k), req_addr, exp_q[k]);
      tick();
    end
    chk("dup_empty_valid", 64'(req_valid), 64'h0);

    drive(64'h8000, 64'h8040, 64'h8080, 3'b111, 1'b0);
    tick();
    expect_state("pre_rst", 1'b1, 64'h8000, 3, 4);
    drive(64'h9000, 64'h9040, 64'h9080, 3'b111, 1'b1);
    rst = 1'b1;
    tick();
    expect_state("mid_rst", 1'b0, 64'h0, 0, 0);
    chk("mid_rst_addr", req_addr, 64'h0);
    rst = 1'b0;
    drive(64'h0, 64'h0, 64'h0, 3'b000, 1'b0);
    tick();
    expect_state("post_rst", 1'b0, 64'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
